// File: rtl/spice_node_integrator.sv
// Charge integrator for one analog netlist node: sums signed branch currents,
// scales by node capacitance and accumulates into a rail-clamped voltage.
module spice_node_integrator #(
    parameter int W        = 15,
    parameter int N        = 4,
    parameter int CSHIFT   = 2,
    parameter int VHI      = 8191,
    parameter int VLO      = -8193,
    parameter int VINIT    = -8193,
    parameter int THRESH   = 1,
    parameter int SETTLE_N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clear,
    input  logic [N*(W+1)-1:0] i_bus,
    output logic [W:0]         v,
    output logic               p,
    output logic               settled,
    output logic               sat
);

    localparam int WW = W + 1;
    localparam int SW = WW + $clog2(N);
    localparam int NW = SW + 1;

    localparam logic signed [NW-1:0] RAIL_HI = NW'(VHI);
    localparam logic signed [NW-1:0] RAIL_LO = NW'(VLO);
    localparam logic signed [NW-1:0] QUIET_HI = NW'(THRESH);
    localparam logic signed [NW-1:0] QUIET_LO = NW'(-THRESH);
    localparam logic signed [W:0]    V_RESET = WW'(VINIT);
    localparam logic [7:0]           SETTLE_MAX = 8'(SETTLE_N);

    logic signed [W:0]    v_q, v_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 settled_q, settled_d;
    logic                 sat_q, sat_d;

    logic signed [SW-1:0] sum;
    logic signed [NW-1:0] delta;
    logic signed [NW-1:0] raw;
    logic signed [NW-1:0] clamped;
    logic                 quiet;
    logic                 clampHit;

    // Sum is wide enough that adding N full-scale currents cannot overflow.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + SW'($signed(i_bus[k*WW +: WW]));
        end
        delta = NW'(sum >>> CSHIFT);
        raw   = NW'(v_q) + delta;
        quiet = (delta <= QUIET_HI) && (delta >= QUIET_LO);

        clampHit = 1'b0;
        clamped  = raw;
        if (raw > RAIL_HI) begin
            clamped  = RAIL_HI;
            clampHit = 1'b1;
        end else if (raw < RAIL_LO) begin
            clamped  = RAIL_LO;
            clampHit = 1'b1;
        end
    end

    // Quietness is judged on the unclamped delta, so a node pinned at a rail
    // by a large current never reports convergence.
    always_comb begin
        v_d       = v_q;
        cnt_d     = cnt_q;
        settled_d = settled_q;
        sat_d     = sat_q;
        if (clear) begin
            v_d       = V_RESET;
            cnt_d     = '0;
            settled_d = 1'b0;
            sat_d     = 1'b0;
        end else if (en) begin
            v_d = WW'(clamped);
            if (clampHit) begin
                sat_d = 1'b1;
            end
            if (!quiet) begin
                cnt_d = '0;
            end else if (cnt_q < SETTLE_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            settled_d = (cnt_d == SETTLE_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= V_RESET;
            cnt_q     <= '0;
            settled_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
            sat_q     <= sat_d;
        end
    end

    assign v       = v_q;
    assign p       = ~v_q[W];
    assign settled = settled_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_spice_node_integrator.sv
// Self-checking bench for spice_node_integrator: directed scenarios plus
// randomized steps compared against an integer reference model.
module tb_spice_node_integrator;

    localparam int VHI      = 8191;
    localparam int VLO      = -8193;
    localparam int VINIT    = -8193;
    localparam int CSHIFT   = 2;
    localparam int THRESH   = 1;
    localparam int SETTLE_N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic [63:0] iBus;
    logic [15:0] v;
    logic        p;
    logic        settled;
    logic        sat;

    int checks = 0;
    int errors = 0;

    int mV;
    int mCnt;
    int mSettled;
    int mSat;

    spice_node_integrator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clear   (clear),
        .i_bus   (iBus),
        .v       (v),
        .p       (p),
        .settled (settled),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mV       = VINIT;
        mCnt     = 0;
        mSettled = 0;
        mSat     = 0;
    endtask

    // Reference behaviour straight from the node equations in integer math.
    task automatic modelStep(input logic doEn, input logic doClear,
                             input int c0, input int c1, input int c2, input int c3);
        int total;
        int delta;
        int nxt;
        if (doClear) begin
            modelReset();
        end else if (doEn) begin
            total = c0 + c1 + c2 + c3;
            delta = total >>> CSHIFT;
            nxt   = mV + delta;
            if (nxt > VHI) begin
                nxt  = VHI;
                mSat = 1;
            end else if (nxt < VLO) begin
                nxt  = VLO;
                mSat = 1;
            end
            mV = nxt;
            if (delta <= THRESH && delta >= -THRESH) begin
                if (mCnt < SETTLE_N) mCnt++;
            end else begin
                mCnt = 0;
            end
            mSettled = (mCnt == SETTLE_N) ? 1 : 0;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_v"}, int'($signed(v)), mV);
        checkOutput({tag, "_p"}, int'(p), (mV >= 0) ? 1 : 0);
        checkOutput({tag, "_settled"}, int'(settled), mSettled);
        checkOutput({tag, "_sat"}, int'(sat), mSat);
    endtask

    task automatic applyStimulus(input string tag, input logic doEn, input logic doClear,
                                 input int c0, input int c1, input int c2, input int c3);
        en    = doEn;
        clear = doClear;
        iBus  = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        @(posedge clk);
        #1;
        modelStep(doEn, doClear, c0, c1, c2, c3);
        checkModel(tag);
    endtask

    function automatic int randCurrent(input int mode);
        case (mode)
            0:       return int'($urandom_range(0, 8)) - 4;
            1:       return int'($urandom_range(0, 600)) - 300;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        iBus  = '0;
        modelReset();
        #12;
        checkOutput("reset_v", int'($signed(v)), -8193);
        checkOutput("reset_p", int'(p), 0);
        checkOutput("reset_settled", int'(settled), 0);
        checkOutput("reset_sat", int'(sat), 0);
        rst_n = 1'b1;

        applyStimulus("basic", 1'b1, 1'b0, 100, 100, 100, 100);
        checkOutput("basic_const_v", int'($signed(v)), -8093);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("idle", 1'b0, 1'b0, 555, -200, 7, 9);
        end
        checkOutput("idle_const_v", int'($signed(v)), -8093);

        applyStimulus("clr1", 1'b0, 1'b1, 0, 0, 0, 0);
        applyStimulus("lowclamp", 1'b1, 1'b0, -1, -1, -1, 0);
        checkOutput("lowclamp_const_v", int'($signed(v)), -8193);
        checkOutput("lowclamp_const_sat", int'(sat), 1);

        applyStimulus("clr2", 1'b0, 1'b1, 0, 0, 0, 0);
        applyStimulus("high1", 1'b1, 1'b0, 8000, 8000, 8000, 8000);
        checkOutput("high1_const_v", int'($signed(v)), -193);
        applyStimulus("high2", 1'b1, 1'b0, 8000, 8000, 8000, 8000);
        checkOutput("high2_const_v", int'($signed(v)), 7807);
        checkOutput("high2_const_p", int'(p), 1);
        applyStimulus("high3", 1'b1, 1'b0, 8000, 8000, 8000, 8000);
        checkOutput("high3_const_v", int'($signed(v)), 8191);
        checkOutput("high3_const_sat", int'(sat), 1);
        applyStimulus("high4", 1'b1, 1'b0, 8000, 8000, 8000, 8000);
        checkOutput("high4_const_v", int'($signed(v)), 8191);
        checkOutput("high4_const_settled", int'(settled), 0);

        applyStimulus("clrprio", 1'b1, 1'b1, 900, -40, 3000, 12);
        checkOutput("clrprio_const_v", int'($signed(v)), -8193);
        checkOutput("clrprio_const_sat", int'(sat), 0);
        checkOutput("clrprio_const_settled", int'(settled), 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("settleA", 1'b1, 1'b0, 0, 0, 0, 0);
            checkOutput("settleA_const", int'(settled), (i == 3) ? 1 : 0);
        end
        applyStimulus("kick", 1'b1, 1'b0, 20, 0, 0, 0);
        checkOutput("kick_const_settled", int'(settled), 0);
        checkOutput("kick_const_v", int'($signed(v)), -8188);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("settleB", 1'b1, 1'b0, 0, 1, 0, 0);
            checkOutput("settleB_const", int'(settled), (i == 3) ? 1 : 0);
        end

        for (int i = 0; i < 400; i++) begin
            int r;
            int mode;
            r    = int'($urandom_range(0, 99));
            mode = int'($urandom_range(0, 2));
            applyStimulus("rand", r < 75, r < 3,
                          randCurrent(mode), randCurrent(mode),
                          randCurrent(mode), randCurrent(mode));
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus("prerst", 1'b1, 1'b0, 3000, 1000, 0, 0);
        end
        en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_v", int'($signed(v)), -8193);
        checkOutput("async_p", int'(p), 0);
        checkOutput("async_settled", int'(settled), 0);
        checkOutput("async_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postrst", 1'b1, 1'b0, 100, 100, 100, 100);
        checkOutput("postrst_const_v", int'($signed(v)), -8093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spice_node_integrator.md
Name: spice_node_integrator

Overview:
- Clocked charge integrator for one circuit node in the switch-level analog netlist fabric.
- Sums N signed branch currents from the transistor, pullup and pin models, scales the sum by a node-capacitance shift, and accumulates it into a rail-clamped node voltage.
- Generalises node handling to parametric width, fan-in and capacitance. Adds a convergence (settle) detector and a saturation flag for the step scheduler.

Parameters:
- W, 15, MSB index of voltage/current words (words are W+1 bits, two's complement).
- N, 4, number of current inputs.
- CSHIFT, 2, capacitance: per-step delta = floor(sum >> CSHIFT).
- VHI, 8191, upper rail (logic-high voltage).
- VLO, -8193, lower rail (logic-low voltage).
- VINIT, -8193, voltage loaded at reset and on clear.
- THRESH, 1, max |delta| counted as a quiet step.
- SETTLE_N, 4, consecutive quiet steps required to assert settled (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  integration step strobe.
- clear  in  1  synchronous reinitialise.
- i_bus  in  N*(W+1)  packed signed currents; channel k occupies bits [k*(W+1)+W : k*(W+1)].
- v  out  W+1  signed node voltage.
- p  out  1  logic level = ~v[W].
- settled  out  1  node converged.
- sat  out  1  sticky: a rail clamp occurred.

Behaviour:
- Reset (async, rst_n=0): v=VINIT, settle count=0, settled=0, sat=0. Recovery is synchronous to clk.
- Priority at each rising edge: clear, then en, then hold.
- clear=1: same reset values as rst_n. Overrides en in the same cycle.
- en=1, clear=0:
  - sum = sign-extended total of all N channels, width W+1+clog2(N); the add never overflows.
  - delta = arithmetic right shift of sum by CSHIFT (floor toward -inf; e.g. -3>>2 = -1).
  - next = v + delta at full width, then clamped to [VLO, VHI].
  - If clamped: sat<=1. sat is sticky until clear or reset.
  - v takes next on this edge: one-cycle latency, p follows combinationally from v.
- Settle counter (0..SETTLE_N, saturating), updated only on en steps:
  - Quiet step (|delta| <= THRESH, computed pre-clamp): count+1, saturating at SETTLE_N.
  - Non-quiet step: count<=0.
- settled is registered, asserted on the edge where count reaches SETTLE_N. It drops on the same edge as any non-quiet step.
- A step that clamps with |delta| > THRESH is non-quiet even though v does not move.
- en=0: v, count, settled and sat hold.
- i_bus is sampled only on en edges; there is no internal pipeline beyond the single state register.
- Reset or clear mid-settle: count restarts at 0; settled needs SETTLE_N fresh quiet steps.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle -> v=-8193, p=0, settled=0, sat=0 immediately, before any clk edge.
- Basic step: v=-8193, i={100,100,100,100}, one en pulse -> v=-8093 after that edge. Three idle cycles -> v stays -8093.
- Floor rounding and low clamp: v=-8193, i={-1,-1,-1,0}, en -> delta=-1, v stays -8193, sat=1.
- High saturation: i={8000,8000,8000,8000}, en held for 4 cycles -> v reaches 8191 and stays there, p=1 once v>=0, sat=1 and stays 1.
- Settle: i=0, 4 en steps -> settled=1 after the 4th edge. Then i={20,0,0,0} with en -> delta=5, settled=0 on that edge. Four more quiet steps are needed to reassert.
- Clear priority: clear=1 and en=1 in the same cycle with nonzero currents -> v=-8193, settled=0, sat=0. No integration occurs in that cycle.
